// File: rtl/mem_read_burst_ctrl.sv
// Splits one burst read request into single-word read commands on the DDR3
// app port and forwards the returned words, then pulses rd_burst_finish.
module mem_read_burst_ctrl #(
    parameter int MEM_DATA_BITS = 32,
    parameter int ADDR_BITS     = 23,
    parameter int BUSRT_BITS    = 10,
    parameter int ADDR_STEP     = 8
) (
    input  logic                     mem_clk,
    input  logic                     rst,
    input  logic                     rd_burst_req,
    input  logic [BUSRT_BITS-1:0]    rd_burst_len,
    input  logic [ADDR_BITS-1:0]     rd_burst_addr,
    output logic                     rd_burst_data_valid,
    output logic [MEM_DATA_BITS-1:0] rd_burst_data,
    output logic                     rd_burst_finish,
    output logic                     busy,
    output logic                     app_en,
    output logic [2:0]               app_cmd,
    output logic [ADDR_BITS-1:0]     app_addr,
    input  logic                     app_rdy,
    input  logic                     app_rd_data_valid,
    input  logic [MEM_DATA_BITS-1:0] app_rd_data
);
    localparam int CW = BUSRT_BITS + 1;
    localparam logic [ADDR_BITS-1:0] STEP = ADDR_BITS'(ADDR_STEP);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_WAIT, S_FINISH} state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            len_q, len_d;
    logic [CW-1:0]            cmd_cnt_q, cmd_cnt_d;
    logic [CW-1:0]            data_cnt_q, data_cnt_d;
    logic                     armed_q, armed_d;
    logic                     app_en_q, app_en_d;
    logic [ADDR_BITS-1:0]     app_addr_q, app_addr_d;
    logic                     valid_q, valid_d;
    logic [MEM_DATA_BITS-1:0] data_q, data_d;
    logic                     finish_q, finish_d;
    logic                     data_phase;
    logic                     accept;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cmd_cnt_d  = cmd_cnt_q;
        data_cnt_d = data_cnt_q;
        armed_d    = armed_q;
        app_en_d   = app_en_q;
        app_addr_d = app_addr_q;
        valid_d    = 1'b0;
        data_d     = data_q;
        finish_d   = 1'b0;
        data_phase = (state_q == S_CMD) || (state_q == S_WAIT);
        accept     = app_en_q && app_rdy;

        // A request must be seen low once before it can start another burst.
        if (!rd_burst_req) armed_d = 1'b1;

        if (data_phase && app_rd_data_valid) begin
            valid_d    = 1'b1;
            data_d     = app_rd_data;
            data_cnt_d = data_cnt_q + CW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (rd_burst_req && armed_q) begin
                    armed_d    = 1'b0;
                    len_d      = CW'(rd_burst_len);
                    cmd_cnt_d  = '0;
                    data_cnt_d = '0;
                    app_addr_d = rd_burst_addr;
                    if (rd_burst_len == '0) begin
                        state_d  = S_FINISH;
                        finish_d = 1'b1;
                    end else begin
                        state_d  = S_CMD;
                        app_en_d = 1'b1;
                    end
                end
            end
            S_CMD: begin
                if (data_cnt_q == len_q) begin
                    state_d  = S_FINISH;
                    finish_d = 1'b1;
                    app_en_d = 1'b0;
                end else if (accept) begin
                    cmd_cnt_d  = cmd_cnt_q + CW'(1);
                    app_addr_d = app_addr_q + STEP;
                    if (cmd_cnt_q + CW'(1) == len_q) begin
                        app_en_d = 1'b0;
                        state_d  = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (data_cnt_q == len_q) begin
                    state_d  = S_FINISH;
                    finish_d = 1'b1;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            cmd_cnt_q  <= '0;
            data_cnt_q <= '0;
            armed_q    <= 1'b0;
            app_en_q   <= 1'b0;
            app_addr_q <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            finish_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cmd_cnt_q  <= cmd_cnt_d;
            data_cnt_q <= data_cnt_d;
            armed_q    <= armed_d;
            app_en_q   <= app_en_d;
            app_addr_q <= app_addr_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            finish_q   <= finish_d;
        end
    end

    assign rd_burst_data_valid = valid_q;
    assign rd_burst_data       = data_q;
    assign rd_burst_finish     = finish_q;
    assign busy                = (state_q != S_IDLE);
    assign app_en              = app_en_q;
    assign app_cmd             = 3'b001;
    assign app_addr            = app_addr_q;

endmodule

// File: tb/tb_mem_read_burst_ctrl.sv
// Directed bench for mem_read_burst_ctrl with a small app-port responder that
// returns a word derived from each accepted command address.
module tb_mem_read_burst_ctrl;
    logic        mem_clk = 1'b0;
    logic        rst;
    logic        rd_burst_req;
    logic [9:0]  rd_burst_len;
    logic [22:0] rd_burst_addr;
    logic        rd_burst_data_valid;
    logic [31:0] rd_burst_data;
    logic        rd_burst_finish;
    logic        busy;
    logic        app_en;
    logic [2:0]  app_cmd;
    logic [22:0] app_addr;
    logic        app_rdy;
    logic        app_rd_data_valid;
    logic [31:0] app_rd_data;

    mem_read_burst_ctrl dut (
        .mem_clk(mem_clk), .rst(rst),
        .rd_burst_req(rd_burst_req), .rd_burst_len(rd_burst_len),
        .rd_burst_addr(rd_burst_addr), .rd_burst_data_valid(rd_burst_data_valid),
        .rd_burst_data(rd_burst_data), .rd_burst_finish(rd_burst_finish),
        .busy(busy), .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
        .app_rdy(app_rdy), .app_rd_data_valid(app_rd_data_valid),
        .app_rd_data(app_rd_data)
    );

    always #5 mem_clk = ~mem_clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge mem_clk) cyc <= cyc + 1;

    logic [31:0] exp_q[$];
    logic [22:0] exp_addr_q[$];
    logic [22:0] pend_q[$];

    int   acc_cnt, valid_cnt, finish_cnt;
    int   first_acc_cyc, last_acc_cyc, last_valid_cyc, finish_cyc, start_cyc;
    logic [22:0] last_acc_addr, stall_addr, pa, ea;
    logic [31:0] ew;
    bit   en_seen, stall_pend, gap_tog;
    int   rdy_mode;
    bit   resp_en, data_gap;

    function automatic logic [31:0] word_of(input logic [22:0] a);
        return {9'h155, a};
    endfunction

    // Monitor and app-port responder; acts on the falling edge only.
    always @(negedge mem_clk) begin
        if (stall_pend && !rst) begin
            total++;
            if (app_en !== 1'b1 || app_addr !== stall_addr) begin
                bad++;
                $display("FAIL stall_hold: app_en=%0b app_addr=%h required app_en=1 app_addr=%h",
                         app_en, app_addr, stall_addr);
            end
        end
        stall_pend = 1'b0;
        if (app_en === 1'b1) en_seen = 1'b1;
        if (rd_burst_data_valid === 1'b1) begin
            valid_cnt++;
            last_valid_cyc = cyc;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rd_data_unexpected: got %h required no word", rd_burst_data);
            end else begin
                ew = exp_q.pop_front();
                if (rd_burst_data !== ew) begin
                    bad++;
                    $display("FAIL rd_data: got %h required %h", rd_burst_data, ew);
                end
            end
        end
        if (rd_burst_finish === 1'b1) begin
            finish_cnt++;
            finish_cyc = cyc;
        end
        if (resp_en && pend_q.size() > 0 && !(data_gap && gap_tog)) begin
            pa = pend_q.pop_front();
            app_rd_data_valid = 1'b1;
            app_rd_data = word_of(pa);
        end else begin
            app_rd_data_valid = 1'b0;
            app_rd_data = '0;
        end
        gap_tog = ~gap_tog;
        case (rdy_mode)
            0: app_rdy = 1'b1;
            1: app_rdy = ~app_rdy;
            default: app_rdy = 1'b0;
        endcase
        if (app_en === 1'b1 && app_rdy) begin
            if (acc_cnt == 0) first_acc_cyc = cyc;
            last_acc_cyc = cyc;
            acc_cnt++;
            last_acc_addr = app_addr;
            pend_q.push_back(app_addr);
            total++;
            if (exp_addr_q.size() == 0) begin
                bad++;
                $display("FAIL app_addr_unexpected: got %h required no command", app_addr);
            end else begin
                ea = exp_addr_q.pop_front();
                if (app_addr !== ea) begin
                    bad++;
                    $display("FAIL app_addr: got %h required %h", app_addr, ea);
                end
            end
        end else if (app_en === 1'b1) begin
            stall_pend = 1'b1;
            stall_addr = app_addr;
        end
    end

    task automatic clear_stats();
        acc_cnt = 0; valid_cnt = 0; finish_cnt = 0; en_seen = 1'b0;
        first_acc_cyc = -1; last_acc_cyc = -1; last_valid_cyc = -100; finish_cyc = -1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge mem_clk); #1;
        end
    endtask

    task automatic start_burst(input int len, input logic [22:0] addr, input bit hold);
        logic [22:0] a;
        for (int i = 0; i < len; i++) begin
            a = addr + 23'(i * 8);
            exp_addr_q.push_back(a);
            exp_q.push_back(word_of(a));
        end
        @(posedge mem_clk); #1;
        start_cyc = cyc;
        rd_burst_req = 1'b1;
        rd_burst_len = 10'(len);
        rd_burst_addr = addr;
        if (!hold) begin
            @(posedge mem_clk); #1;
            rd_burst_req = 1'b0;
        end
    endtask

    task automatic wait_finish(input int target, input int budget, input string name);
        int i;
        for (i = 0; i < budget; i++) begin
            @(posedge mem_clk); #1;
            if (finish_cnt >= target) break;
        end
        total++;
        if (finish_cnt < target) begin
            bad++;
            $display("FAIL %s_timeout: finish_cnt=%0d required %0d within %0d cycles",
                     name, finish_cnt, target, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        total++;
        if ({rd_burst_data_valid, rd_burst_data, rd_burst_finish, busy, app_en, app_addr} !== '0
            || app_cmd !== 3'b001) begin
            bad++;
            $display("FAIL reset_outputs: valid=%0b data=%h fin=%0b busy=%0b en=%0b addr=%h cmd=%b required all 0, cmd=001",
                     rd_burst_data_valid, rd_burst_data, rd_burst_finish, busy, app_en, app_addr, app_cmd);
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_basic();
        clear_stats();
        start_burst(4, 23'h000100, 1'b0);
        wait_finish(1, 100, "basic");
        idle(3);
        total++;
        if (acc_cnt !== 4 || last_acc_cyc - first_acc_cyc !== 3) begin
            bad++;
            $display("FAIL basic_cmds: accepts=%0d span=%0d required 4 and 3",
                     acc_cnt, last_acc_cyc - first_acc_cyc);
        end
        total++;
        if (valid_cnt !== 4 || finish_cnt !== 1 || finish_cyc !== last_valid_cyc + 1) begin
            bad++;
            $display("FAIL basic_finish: valids=%0d finishes=%0d fin_cyc=%0d last_valid=%0d required 4, 1, last_valid+1",
                     valid_cnt, finish_cnt, finish_cyc, last_valid_cyc);
        end
        total++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL basic_idle: busy=%0b words_left=%0d required 0 and 0", busy, exp_q.size());
        end
    endtask

    task automatic test_stall();
        clear_stats();
        rdy_mode = 1;
        start_burst(128, 23'h001000, 1'b0);
        wait_finish(1, 2000, "stall");
        idle(3);
        rdy_mode = 0;
        total++;
        if (acc_cnt !== 128 || valid_cnt !== 128 || finish_cnt !== 1) begin
            bad++;
            $display("FAIL stall_counts: accepts=%0d valids=%0d finishes=%0d required 128, 128, 1",
                     acc_cnt, valid_cnt, finish_cnt);
        end
        total++;
        if (finish_cyc !== last_valid_cyc + 1 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL stall_finish: fin_cyc=%0d last_valid=%0d words_left=%0d required last_valid+1 and 0",
                     finish_cyc, last_valid_cyc, exp_q.size());
        end
    endtask

    task automatic test_zero_len();
        int c1;
        clear_stats();
        start_burst(0, 23'h000200, 1'b1);
        c1 = start_cyc;
        idle(10);
        total++;
        if (finish_cnt !== 1 || finish_cyc !== c1 + 1) begin
            bad++;
            $display("FAIL zero_len_finish: finishes=%0d fin_cyc=%0d required 1 and %0d",
                     finish_cnt, finish_cyc, c1 + 1);
        end
        total++;
        if (en_seen !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_len_rearm: app_en_seen=%0b busy=%0b required 0 and 0", en_seen, busy);
        end
        rd_burst_req = 1'b0;
        @(posedge mem_clk); #1;
        rd_burst_req = 1'b1;
        c1 = cyc;
        idle(4);
        rd_burst_req = 1'b0;
        total++;
        if (finish_cnt !== 2 || finish_cyc !== c1 + 1 || en_seen !== 1'b0) begin
            bad++;
            $display("FAIL zero_len_second: finishes=%0d fin_cyc=%0d app_en_seen=%0b required 2, %0d, 0",
                     finish_cnt, finish_cyc, en_seen, c1 + 1);
        end
        idle(2);
    endtask

    task automatic test_addr_wrap();
        clear_stats();
        start_burst(2, 23'h7FFFF8, 1'b0);
        wait_finish(1, 100, "wrap");
        idle(3);
        total++;
        if (acc_cnt !== 2 || last_acc_addr !== 23'h000000) begin
            bad++;
            $display("FAIL wrap_addr: accepts=%0d last_addr=%h required 2 and 000000", acc_cnt, last_acc_addr);
        end
    endtask

    task automatic test_mid_reset();
        int i;
        clear_stats();
        resp_en = 1'b0;
        start_burst(8, 23'h000400, 1'b0);
        for (i = 0; i < 50; i++) begin
            if (acc_cnt >= 3) break;
            @(posedge mem_clk); #1;
        end
        rst = 1'b1;
        rdy_mode = 2;
        @(posedge mem_clk); #1;
        total++;
        if (acc_cnt !== 3) begin
            bad++;
            $display("FAIL mid_reset_accepts: accepts=%0d required 3", acc_cnt);
        end
        total++;
        if ({rd_burst_data_valid, rd_burst_data, rd_burst_finish, busy, app_en, app_addr} !== '0
            || app_cmd !== 3'b001) begin
            bad++;
            $display("FAIL mid_reset_outputs: valid=%0b data=%h fin=%0b busy=%0b en=%0b addr=%h cmd=%b required all 0, cmd=001",
                     rd_burst_data_valid, rd_burst_data, rd_burst_finish, busy, app_en, app_addr, app_cmd);
        end
        exp_q.delete();
        exp_addr_q.delete();
        idle(1);
        rst = 1'b0;
        resp_en = 1'b1;
        for (i = 0; i < 20; i++) begin
            if (pend_q.size() == 0) break;
            @(posedge mem_clk); #1;
        end
        idle(3);
        total++;
        if (valid_cnt !== 0 || finish_cnt !== 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_late_data: valids=%0d finishes=%0d busy=%0b required 0, 0, 0",
                     valid_cnt, finish_cnt, busy);
        end
        rdy_mode = 0;
        idle(2);
    endtask

    task automatic test_interleave();
        clear_stats();
        data_gap = 1'b1;
        start_burst(6, 23'h000040, 1'b0);
        wait_finish(1, 200, "interleave");
        idle(3);
        data_gap = 1'b0;
        total++;
        if (acc_cnt !== 6 || valid_cnt !== 6 || finish_cnt !== 1
            || finish_cyc !== last_valid_cyc + 1) begin
            bad++;
            $display("FAIL interleave: accepts=%0d valids=%0d finishes=%0d fin_cyc=%0d last_valid=%0d required 6, 6, 1, last_valid+1",
                     acc_cnt, valid_cnt, finish_cnt, finish_cyc, last_valid_cyc);
        end
    endtask

    task automatic test_back_to_back();
        clear_stats();
        start_burst(1, 23'h000300, 1'b0);
        wait_finish(1, 100, "b2b_first");
        start_burst(3, 23'h000500, 1'b0);
        wait_finish(2, 100, "b2b_second");
        idle(3);
        total++;
        if (acc_cnt !== 4 || valid_cnt !== 4 || finish_cnt !== 2 || exp_q.size() != 0
            || finish_cyc !== last_valid_cyc + 1) begin
            bad++;
            $display("FAIL back_to_back: accepts=%0d valids=%0d finishes=%0d words_left=%0d required 4, 4, 2, 0",
                     acc_cnt, valid_cnt, finish_cnt, exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        rd_burst_req = 1'b0;
        rd_burst_len = '0;
        rd_burst_addr = '0;
        app_rdy = 1'b0;
        app_rd_data_valid = 1'b0;
        app_rd_data = '0;
        rdy_mode = 0;
        resp_en = 1'b1;
        data_gap = 1'b0;
        gap_tog = 1'b0;
        stall_pend = 1'b0;
        clear_stats();
        test_reset();
        test_basic();
        test_stall();
        test_zero_len();
        test_addr_wrap();
        test_mid_reset();
        test_interleave();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
